mem_wb_pipe: RTL

- Pipeline register between the dual-issue MEM stage and the write-back stage.
- Latches both issue slots' results each cycle. Supports stall (hold) and flush (bubble).
- Captures synchronous data-SRAM read data for slot-first loads and formats it by load type and byte offset, producing Mem_Result_First for write-back.
- Holds the formatted load result stable across WB stalls, after the SRAM output has moved on.

---
 rtl/mem_wb_pipe_if.sv | 73 +++++++
 rtl/mem_wb_pipe.sv | 110 +++++++++++
 2 files changed

// File: rtl/mem_wb_pipe_if.sv
// MEM-to-WB pipeline bundle: MEM-stage results and controls in, registered WB copies out.
// The producer side (MEM stage / bench) uses master; the pipeline register uses slave.
interface mem_wb_pipe_if #(parameter int DW = 32);
   logic          stall;
   logic          flush;
   logic          Mem_Valid;
   logic          Write_Reg_Enable_First;
   logic          Write_Reg_Enable_Second;
   logic [4:0]    Write_Reg_Address_First;
   logic [4:0]    Write_Reg_Address_Second;
   logic [1:0]    Write_HILO_Enable_First;
   logic [63:0]   Write_HILO_Data;
   logic [1:0]    LS_First;
   logic [2:0]    Load_Type_First;
   logic [1:0]    Mem_Addr_Low_First;
   logic [DW-1:0] Aluout_First;
   logic [DW-1:0] Aluout_Second;
   logic          Write_Cp0_Enable_First;
   logic [7:0]    Cp0_write_address_First;
   logic [DW-1:0] Cp0_write_data_First;
   logic [DW-1:0] data_sram_rdata;

   logic          WB_Valid;
   logic          Write_Reg_Enable_First_wb;
   logic          Write_Reg_Enable_Second_wb;
   logic [4:0]    Write_Reg_Address_First_wb;
   logic [4:0]    Write_Reg_Address_Second_wb;
   logic [1:0]    Write_HILO_Enable_First_wb;
   logic [63:0]   Write_HILO_Data_wb;
   logic [1:0]    LS_First_wb;
   logic [DW-1:0] Aluout_First_wb;
   logic [DW-1:0] Aluout_Second_wb;
   logic          Write_Cp0_Enable_First_wb;
   logic [7:0]    Cp0_write_address_First_wb;
   logic [DW-1:0] Cp0_write_data_First_wb;
   logic [DW-1:0] Mem_Result_First;

   modport master (
      output stall, flush, Mem_Valid,
             Write_Reg_Enable_First, Write_Reg_Enable_Second,
             Write_Reg_Address_First, Write_Reg_Address_Second,
             Write_HILO_Enable_First, Write_HILO_Data,
             LS_First, Load_Type_First, Mem_Addr_Low_First,
             Aluout_First, Aluout_Second,
             Write_Cp0_Enable_First, Cp0_write_address_First, Cp0_write_data_First,
             data_sram_rdata,
      input  WB_Valid,
             Write_Reg_Enable_First_wb, Write_Reg_Enable_Second_wb,
             Write_Reg_Address_First_wb, Write_Reg_Address_Second_wb,
             Write_HILO_Enable_First_wb, Write_HILO_Data_wb, LS_First_wb,
             Aluout_First_wb, Aluout_Second_wb,
             Write_Cp0_Enable_First_wb, Cp0_write_address_First_wb, Cp0_write_data_First_wb,
             Mem_Result_First
   );

   modport slave (
      input  stall, flush, Mem_Valid,
             Write_Reg_Enable_First, Write_Reg_Enable_Second,
             Write_Reg_Address_First, Write_Reg_Address_Second,
             Write_HILO_Enable_First, Write_HILO_Data,
             LS_First, Load_Type_First, Mem_Addr_Low_First,
             Aluout_First, Aluout_Second,
             Write_Cp0_Enable_First, Cp0_write_address_First, Cp0_write_data_First,
             data_sram_rdata,
      output WB_Valid,
             Write_Reg_Enable_First_wb, Write_Reg_Enable_Second_wb,
             Write_Reg_Address_First_wb, Write_Reg_Address_Second_wb,
             Write_HILO_Enable_First_wb, Write_HILO_Data_wb, LS_First_wb,
             Aluout_First_wb, Aluout_Second_wb,
             Write_Cp0_Enable_First_wb, Cp0_write_address_First_wb, Cp0_write_data_First_wb,
             Mem_Result_First
   );
endinterface

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register for a dual-issue pipe with stall/flush, plus slot-first
// load-data capture and byte/halfword formatting that stays stable across WB stalls.
module mem_wb_pipe #(
   parameter int DW = 32
) (
   input logic          clk,
   input logic          resetn,
   mem_wb_pipe_if.slave bus
);

   typedef enum logic [2:0] {
      LD_W  = 3'b000,
      LD_B  = 3'b001,
      LD_BU = 3'b010,
      LD_H  = 3'b011,
      LD_HU = 3'b100
   } load_type_e;

   localparam logic [1:0] LS_LOAD = 2'b01;

   logic [2:0]    load_type_wb;
   logic [1:0]    offset_wb;
   logic [DW-1:0] rdata_buf;
   logic          buf_valid;
   logic          first_cycle;

   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         bus.WB_Valid                    <= 1'b0;
         bus.Write_Reg_Enable_First_wb   <= 1'b0;
         bus.Write_Reg_Enable_Second_wb  <= 1'b0;
         bus.Write_Reg_Address_First_wb  <= '0;
         bus.Write_Reg_Address_Second_wb <= '0;
         bus.Write_HILO_Enable_First_wb  <= '0;
         bus.Write_HILO_Data_wb          <= '0;
         bus.LS_First_wb                 <= '0;
         bus.Aluout_First_wb             <= '0;
         bus.Aluout_Second_wb            <= '0;
         bus.Write_Cp0_Enable_First_wb   <= 1'b0;
         bus.Cp0_write_address_First_wb  <= '0;
         bus.Cp0_write_data_First_wb     <= '0;
         load_type_wb                    <= '0;
         offset_wb                       <= '0;
         rdata_buf                       <= '0;
         buf_valid                       <= 1'b0;
         first_cycle                     <= 1'b0;
      end else if (bus.flush) begin
         // Bubble: only the fields that cause side effects are cleared.
         bus.WB_Valid                   <= 1'b0;
         bus.Write_Reg_Enable_First_wb  <= 1'b0;
         bus.Write_Reg_Enable_Second_wb <= 1'b0;
         bus.Write_HILO_Enable_First_wb <= '0;
         bus.Write_Cp0_Enable_First_wb  <= 1'b0;
         bus.LS_First_wb                <= '0;
         buf_valid                      <= 1'b0;
         first_cycle                    <= 1'b0;
      end else if (bus.stall) begin
         // SRAM data is only valid in the first WB cycle; park it before it moves on.
         if (first_cycle && bus.LS_First_wb == LS_LOAD) begin
            rdata_buf <= bus.data_sram_rdata;
            buf_valid <= 1'b1;
         end
         first_cycle <= 1'b0;
      end else begin
         bus.WB_Valid                    <= bus.Mem_Valid;
         bus.Write_Reg_Enable_First_wb   <= bus.Mem_Valid & bus.Write_Reg_Enable_First;
         bus.Write_Reg_Enable_Second_wb  <= bus.Mem_Valid & bus.Write_Reg_Enable_Second;
         bus.Write_Reg_Address_First_wb  <= bus.Write_Reg_Address_First;
         bus.Write_Reg_Address_Second_wb <= bus.Write_Reg_Address_Second;
         bus.Write_HILO_Enable_First_wb  <= bus.Mem_Valid ? bus.Write_HILO_Enable_First : 2'b00;
         bus.Write_HILO_Data_wb          <= bus.Write_HILO_Data;
         bus.LS_First_wb                 <= bus.Mem_Valid ? bus.LS_First : 2'b00;
         bus.Aluout_First_wb             <= bus.Aluout_First;
         bus.Aluout_Second_wb            <= bus.Aluout_Second;
         bus.Write_Cp0_Enable_First_wb   <= bus.Mem_Valid & bus.Write_Cp0_Enable_First;
         bus.Cp0_write_address_First_wb  <= bus.Cp0_write_address_First;
         bus.Cp0_write_data_First_wb     <= bus.Cp0_write_data_First;
         load_type_wb                    <= bus.Load_Type_First;
         offset_wb                       <= bus.Mem_Addr_Low_First;
         buf_valid                       <= 1'b0;
         first_cycle                     <= bus.Mem_Valid;
      end
   end

   logic [DW-1:0] raw;
   logic [7:0]    byte_sel;
   logic [15:0]   half_sel;
   logic [DW-1:0] result;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      raw      = buf_valid ? rdata_buf : bus.data_sram_rdata;
      byte_sel = raw[{offset_wb, 3'b000} +: 8];
      half_sel = raw[{offset_wb[1], 4'b0000} +: 16];
      result   = '0;
      if (bus.LS_First_wb == LS_LOAD) begin
         case (load_type_wb)
            LD_B:    result = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   result = {24'h0, byte_sel};
            LD_H:    result = {{16{half_sel[15]}}, half_sel};
            LD_HU:   result = {16'h0, half_sel};
            default: result = raw;
         endcase
      end
   end

   assign bus.Mem_Result_First = result;

endmodule
